// File: rtl/opcodes_pkg.sv
// Shared RV32I decode definitions: operation enum, major opcodes, funct7 values
// and the instruction-format classes used to route fields.
package opcodes_pkg;

   localparam int XLEN = 32;

   typedef enum logic [5:0] {
      INVALID,
      LUI, AUIPC, JAL, JALR,
      BEQ, BNE, BLT, BGE, BLTU, BGEU,
      LB, LH, LW, LBU, LHU,
      SB, SH, SW,
      ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI,
      ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND,
      FENCE, ECALL, EBREAK
   } opcode_out_t;

   localparam logic [6:0] OPC_LUI      = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
   localparam logic [6:0] OPC_JAL      = 7'b1101111;
   localparam logic [6:0] OPC_JALR     = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
   localparam logic [6:0] OPC_LOAD     = 7'b0000011;
   localparam logic [6:0] OPC_STORE    = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
   localparam logic [6:0] OPC_OP       = 7'b0110011;
   localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
   localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
   localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

   // FMT_FENCE: rd and rs1 used, zero immediate; FMT_NONE: every field zero.
   typedef enum logic [3:0] {
      FMT_NONE, FMT_R, FMT_I, FMT_SH, FMT_S, FMT_B, FMT_U, FMT_J, FMT_FENCE
   } fmt_t;

endpackage

// File: rtl/decode.sv
// RV32I ID-stage decoder: combinational operation/field extraction plus an
// ID/EX pipeline register with stall (en) and bubble-inserting flush.
module decode
   import opcodes_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [31:0]       instr,
   input  logic              en,
   input  logic              flush,
   output opcode_out_t       opcode_out,
   output logic [4:0]        wr_reg_idx,
   output logic [4:0]        r1_reg_idx,
   output logic [4:0]        r2_reg_idx,
   output logic [31:0]       imm,
   output logic              illegal,
   output opcode_out_t       opcode_q,
   output logic [4:0]        wr_reg_idx_q,
   output logic [4:0]        r1_reg_idx_q,
   output logic [4:0]        r2_reg_idx_q,
   output logic [31:0]       imm_q
);

   opcode_out_t op_s;
   fmt_t        fmt_s;
   logic [2:0]  funct3_s;
   logic [6:0]  funct7_s;
   logic [4:0]  rd_s;
   logic [4:0]  rs1_s;
   logic [4:0]  rs2_s;
   logic [31:0] imm_s;

   assign funct3_s = instr[14:12];
   assign funct7_s = instr[31:25];

   // Operation and format classification from opcode/funct3/funct7.
   always_comb begin
      op_s  = INVALID;
      fmt_s = FMT_NONE;
      case (instr[6:0])
         OPC_LUI:   begin op_s = LUI;   fmt_s = FMT_U; end
         OPC_AUIPC: begin op_s = AUIPC; fmt_s = FMT_U; end
         OPC_JAL:   begin op_s = JAL;   fmt_s = FMT_J; end
         OPC_JALR: begin
            fmt_s = FMT_I;
            if (funct3_s == 3'b000) op_s = JALR;
            else                    op_s = INVALID;
         end
         OPC_BRANCH: begin
            fmt_s = FMT_B;
            case (funct3_s)
               3'b000:  op_s = BEQ;
               3'b001:  op_s = BNE;
               3'b100:  op_s = BLT;
               3'b101:  op_s = BGE;
               3'b110:  op_s = BLTU;
               3'b111:  op_s = BGEU;
               default: op_s = INVALID;
            endcase
         end
         OPC_LOAD: begin
            fmt_s = FMT_I;
            case (funct3_s)
               3'b000:  op_s = LB;
               3'b001:  op_s = LH;
               3'b010:  op_s = LW;
               3'b100:  op_s = LBU;
               3'b101:  op_s = LHU;
               default: op_s = INVALID;
            endcase
         end
         OPC_STORE: begin
            fmt_s = FMT_S;
            case (funct3_s)
               3'b000:  op_s = SB;
               3'b001:  op_s = SH;
               3'b010:  op_s = SW;
               default: op_s = INVALID;
            endcase
         end
         OPC_OP_IMM: begin
            fmt_s = FMT_I;
            case (funct3_s)
               3'b000:  op_s = ADDI;
               3'b010:  op_s = SLTI;
               3'b011:  op_s = SLTIU;
               3'b100:  op_s = XORI;
               3'b110:  op_s = ORI;
               3'b111:  op_s = ANDI;
               3'b001: begin
                  fmt_s = FMT_SH;
                  if (funct7_s == F7_BASE) op_s = SLLI;
                  else                     op_s = INVALID;
               end
               3'b101: begin
                  fmt_s = FMT_SH;
                  if (funct7_s == F7_BASE)     op_s = SRLI;
                  else if (funct7_s == F7_ALT) op_s = SRAI;
                  else                         op_s = INVALID;
               end
               default: op_s = INVALID;
            endcase
         end
         OPC_OP: begin
            fmt_s = FMT_R;
            case ({funct7_s, funct3_s})
               {F7_BASE, 3'b000}: op_s = ADD;
               {F7_BASE, 3'b001}: op_s = SLL;
               {F7_BASE, 3'b010}: op_s = SLT;
               {F7_BASE, 3'b011}: op_s = SLTU;
               {F7_BASE, 3'b100}: op_s = XOR;
               {F7_BASE, 3'b101}: op_s = SRL;
               {F7_BASE, 3'b110}: op_s = OR;
               {F7_BASE, 3'b111}: op_s = AND;
               {F7_ALT,  3'b000}: op_s = SUB;
               {F7_ALT,  3'b101}: op_s = SRA;
               default:           op_s = INVALID;
            endcase
         end
         OPC_MISC_MEM: begin
            fmt_s = FMT_FENCE;
            if (funct3_s == 3'b000) op_s = FENCE;
            else                    op_s = INVALID;
         end
         OPC_SYSTEM: begin
            fmt_s = FMT_NONE;
            if (instr == INSTR_ECALL)       op_s = ECALL;
            else if (instr == INSTR_EBREAK) op_s = EBREAK;
            else                            op_s = INVALID;
         end
         default: begin
            op_s  = INVALID;
            fmt_s = FMT_NONE;
         end
      endcase
   end

   // Field routing by format; an INVALID operation zeroes every field.
   always_comb begin
      rd_s  = 5'd0;
      rs1_s = 5'd0;
      rs2_s = 5'd0;
      imm_s = 32'd0;
      if (op_s != INVALID) begin
         case (fmt_s)
            FMT_R: begin
               rd_s  = instr[11:7];
               rs1_s = instr[19:15];
               rs2_s = instr[24:20];
            end
            FMT_I: begin
               rd_s  = instr[11:7];
               rs1_s = instr[19:15];
               imm_s = {{20{instr[31]}}, instr[31:20]};
            end
            FMT_SH: begin
               rd_s  = instr[11:7];
               rs1_s = instr[19:15];
               imm_s = {27'd0, instr[24:20]};
            end
            FMT_S: begin
               rs1_s = instr[19:15];
               rs2_s = instr[24:20];
               imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            FMT_B: begin
               rs1_s = instr[19:15];
               rs2_s = instr[24:20];
               imm_s = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            end
            FMT_U: begin
               rd_s  = instr[11:7];
               imm_s = {instr[31:12], 12'd0};
            end
            FMT_J: begin
               rd_s  = instr[11:7];
               imm_s = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            end
            FMT_FENCE: begin
               rd_s  = instr[11:7];
               rs1_s = instr[19:15];
            end
            default: begin
               rd_s  = 5'd0;
               rs1_s = 5'd0;
               rs2_s = 5'd0;
               imm_s = 32'd0;
            end
         endcase
      end else begin
         rd_s  = 5'd0;
         rs1_s = 5'd0;
         rs2_s = 5'd0;
         imm_s = 32'd0;
      end
   end

   assign opcode_out = op_s;
   assign wr_reg_idx = rd_s;
   assign r1_reg_idx = rs1_s;
   assign r2_reg_idx = rs2_s;
   assign imm        = imm_s;
   assign illegal    = (op_s == INVALID);

   // ID/EX register: flush beats en, en=0 holds the previous contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         opcode_q     <= INVALID;
         wr_reg_idx_q <= 5'd0;
         r1_reg_idx_q <= 5'd0;
         r2_reg_idx_q <= 5'd0;
         imm_q        <= 32'd0;
      end else if (flush) begin
         opcode_q     <= INVALID;
         wr_reg_idx_q <= 5'd0;
         r1_reg_idx_q <= 5'd0;
         r2_reg_idx_q <= 5'd0;
         imm_q        <= 32'd0;
      end else if (en) begin
         opcode_q     <= op_s;
         wr_reg_idx_q <= rd_s;
         r1_reg_idx_q <= rs1_s;
         r2_reg_idx_q <= rs2_s;
         imm_q        <= imm_s;
      end
   end

endmodule

// File: tb/tb_decode.sv
// Directed, table-driven bench for the RV32I decoder and its ID/EX register.
module tb_decode;
   import opcodes_pkg::*;

   logic        clk;
   logic        rst_n;
   logic [31:0] instr;
   logic        en;
   logic        flush;
   opcode_out_t opcode_out;
   logic [4:0]  wr_reg_idx, r1_reg_idx, r2_reg_idx;
   logic [31:0] imm;
   logic        illegal;
   opcode_out_t opcode_q;
   logic [4:0]  wr_reg_idx_q, r1_reg_idx_q, r2_reg_idx_q;
   logic [31:0] imm_q;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [31:0] instr;
      opcode_out_t op;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [31:0] imm;
   } vec_t;

   localparam int NVEC = 18;
   vec_t vecs [NVEC];

   decode dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .instr        (instr),
      .en           (en),
      .flush        (flush),
      .opcode_out   (opcode_out),
      .wr_reg_idx   (wr_reg_idx),
      .r1_reg_idx   (r1_reg_idx),
      .r2_reg_idx   (r2_reg_idx),
      .imm          (imm),
      .illegal      (illegal),
      .opcode_q     (opcode_q),
      .wr_reg_idx_q (wr_reg_idx_q),
      .r1_reg_idx_q (r1_reg_idx_q),
      .r2_reg_idx_q (r2_reg_idx_q),
      .imm_q        (imm_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_q(input string tag, input opcode_out_t op, input logic [4:0] rd,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] im);
      check({tag, ".opq"},  32'(opcode_q),     32'(op));
      check({tag, ".rdq"},  32'(wr_reg_idx_q), 32'(rd));
      check({tag, ".rs1q"}, 32'(r1_reg_idx_q), 32'(rs1));
      check({tag, ".rs2q"}, 32'(r2_reg_idx_q), 32'(rs2));
      check({tag, ".immq"}, imm_q,             im);
   endtask

   initial begin
      vecs[0]  = '{32'h02A30293, ADDI,    5'd5,  5'd6, 5'd0, 32'd42};
      vecs[1]  = '{32'h003100B3, ADD,     5'd1,  5'd2, 5'd3, 32'd0};
      vecs[2]  = '{32'h403100B3, SUB,     5'd1,  5'd2, 5'd3, 32'd0};
      vecs[3]  = '{32'h01012503, LW,      5'd10, 5'd2, 5'd0, 32'd16};
      vecs[4]  = '{32'h00208663, BEQ,     5'd0,  5'd1, 5'd2, 32'd12};
      vecs[5]  = '{32'hABCDE1B7, LUI,     5'd3,  5'd0, 5'd0, 32'hABCDE000};
      vecs[6]  = '{32'hFFFFFFFF, INVALID, 5'd0,  5'd0, 5'd0, 32'd0};
      vecs[7]  = '{32'h00000000, INVALID, 5'd0,  5'd0, 5'd0, 32'd0};
      vecs[8]  = '{32'h00512423, SW,      5'd0,  5'd2, 5'd5, 32'd8};
      vecs[9]  = '{32'h40345393, SRAI,    5'd7,  5'd8, 5'd0, 32'd3};
      vecs[10] = '{32'hFFDFF0EF, JAL,     5'd1,  5'd0, 5'd0, 32'hFFFFFFFC};
      vecs[11] = '{32'hFFF00093, ADDI,    5'd1,  5'd0, 5'd0, 32'hFFFFFFFF};
      vecs[12] = '{32'h00000073, ECALL,   5'd0,  5'd0, 5'd0, 32'd0};
      vecs[13] = '{32'h00100073, EBREAK,  5'd0,  5'd0, 5'd0, 32'd0};
      vecs[14] = '{32'h00200073, INVALID, 5'd0,  5'd0, 5'd0, 32'd0};
      vecs[15] = '{32'h40109093, INVALID, 5'd0,  5'd0, 5'd0, 32'd0};
      vecs[16] = '{32'h003100B2, INVALID, 5'd0,  5'd0, 5'd0, 32'd0};
      vecs[17] = '{32'h000080E7, JALR,    5'd1,  5'd1, 5'd0, 32'd0};

      rst_n = 1'b0;
      en    = 1'b0;
      flush = 1'b0;
      instr = 32'd0;
      #1;
      check_q("reset", INVALID, 5'd0, 5'd0, 5'd0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      for (int i = 0; i < NVEC; i++) begin
         string tag;
         tag = $sformatf("v%0d", i);
         @(negedge clk);
         instr = vecs[i].instr;
         en    = 1'b1;
         #1;
         check({tag, ".op"},  32'(opcode_out), 32'(vecs[i].op));
         check({tag, ".rd"},  32'(wr_reg_idx), 32'(vecs[i].rd));
         check({tag, ".rs1"}, 32'(r1_reg_idx), 32'(vecs[i].rs1));
         check({tag, ".rs2"}, 32'(r2_reg_idx), 32'(vecs[i].rs2));
         check({tag, ".imm"}, imm,             vecs[i].imm);
         check({tag, ".ill"}, 32'(illegal),    32'(vecs[i].op == INVALID));
         @(posedge clk);
         #1;
         check_q(tag, vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm);
      end

      // Stall: load ADDI, then hold it while ADD sits on the input.
      @(negedge clk);
      instr = 32'h02A30293;
      en    = 1'b1;
      @(posedge clk);
      @(negedge clk);
      en    = 1'b0;
      instr = 32'h003100B3;
      @(posedge clk);
      #1;
      check_q("hold", ADDI, 5'd5, 5'd6, 5'd0, 32'd42);

      // Flush wins over en.
      @(negedge clk);
      en    = 1'b1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      check_q("flush", INVALID, 5'd0, 5'd0, 5'd0, 32'd0);

      // Reload, then drop rst_n between edges.
      @(negedge clk);
      flush = 1'b0;
      instr = 32'hABCDE1B7;
      @(posedge clk);
      #1;
      check_q("reload", LUI, 5'd3, 5'd0, 5'd0, 32'hABCDE000);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_q("midrst", INVALID, 5'd0, 5'd0, 5'd0, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check_q("afterrst", LUI, 5'd3, 5'd0, 5'd0, 32'hABCDE000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
